// File: rtl/alu_req_sched.sv
// Two-requester round-robin scheduler that shares one combinational ALU and
// returns tagged results. Optional perf counters under `ALU_SCHED_PERF_EN.
module alu_req_sched #(
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 4,
  parameter int MAX_SEL = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_out,
  output logic [3:0]        resp_flags,
  output logic              resp_err,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_negative,
  output logic              busy
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [15:0]       perf_cnt0,
  output logic [15:0]       perf_cnt1,
  output logic [7:0]        perf_err_cnt
`endif
);

  // state | meaning
  // IDLE  | waiting for a request; grant and latch operands on accept
  // EXEC  | registered operands drive the ALU; capture result this edge
  // RESP  | response held until the consumer takes it
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              r_state;
  logic                r_ptr;
  logic                r_resp_valid;
  logic                r_resp_id;
  logic [DATA_W-1:0]   r_resp_out;
  logic [3:0]          r_resp_flags;
  logic                r_resp_err;
  logic [DATA_W-1:0]   r_alu_x;
  logic [DATA_W-1:0]   r_alu_y;
  logic [SEL_W-1:0]    r_alu_sel;

  logic                w_gnt_vld;
  logic                w_gnt_id;
  logic [DATA_W-1:0]   w_x;
  logic [DATA_W-1:0]   w_y;
  logic [SEL_W-1:0]    w_sel;
  logic                w_resp_fire;

  // r_ptr names the requester favoured when both are valid
  always_comb begin
    w_gnt_vld = req0_valid | req1_valid;
    w_gnt_id  = (req0_valid & req1_valid) ? r_ptr : req1_valid;
    w_x       = w_gnt_id ? req1_x   : req0_x;
    w_y       = w_gnt_id ? req1_y   : req0_y;
    w_sel     = w_gnt_id ? req1_sel : req0_sel;
  end

  assign req0_ready  = (r_state == IDLE) & w_gnt_vld & ~w_gnt_id;
  assign req1_ready  = (r_state == IDLE) & w_gnt_vld &  w_gnt_id;
  assign busy        = (r_state != IDLE);
  assign w_resp_fire = r_resp_valid & resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_out   <= '0;
      r_resp_flags <= '0;
      r_resp_err   <= 1'b0;
      r_alu_x      <= '0;
      r_alu_y      <= '0;
      r_alu_sel    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_alu_x    <= w_x;
            r_alu_y    <= w_y;
            r_alu_sel  <= w_sel;
            r_resp_id  <= w_gnt_id;
            r_resp_err <= (w_sel > SEL_W'(MAX_SEL));
            r_ptr      <= ~w_gnt_id;
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          r_resp_out   <= alu_out;
          r_resp_flags <= {alu_negative, alu_overflow, alu_carry, alu_zero};
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (w_resp_fire) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_out   = r_resp_out;
  assign resp_flags = r_resp_flags;
  assign resp_err   = r_resp_err;
  assign alu_x      = r_alu_x;
  assign alu_y      = r_alu_y;
  assign alu_sel    = r_alu_sel;

`ifdef ALU_SCHED_PERF_EN
  logic [15:0] r_perf_cnt0;
  logic [15:0] r_perf_cnt1;
  logic [7:0]  r_perf_err_cnt;

  // all counters saturate rather than wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cnt0    <= '0;
      r_perf_cnt1    <= '0;
      r_perf_err_cnt <= '0;
    end else if (w_resp_fire) begin
      if (!r_resp_id && r_perf_cnt0 != 16'hFFFF) r_perf_cnt0 <= r_perf_cnt0 + 16'd1;
      if ( r_resp_id && r_perf_cnt1 != 16'hFFFF) r_perf_cnt1 <= r_perf_cnt1 + 16'd1;
      if (r_resp_err && r_perf_err_cnt != 8'hFF) r_perf_err_cnt <= r_perf_err_cnt + 8'd1;
    end
  end

  assign perf_cnt0    = r_perf_cnt0;
  assign perf_cnt1    = r_perf_cnt1;
  assign perf_err_cnt = r_perf_err_cnt;
`endif

endmodule

// File: tb/tb_alu_req_sched.sv
// Bench for alu_req_sched: directed scenarios plus random traffic scored
// against a transaction-level round-robin model; includes a stand-in ALU.
module tb_alu_req_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_x, req0_y, req1_x, req1_y;
  logic [3:0] req0_sel, req1_sel;
  logic       resp_valid, resp_ready, resp_id, resp_err;
  logic [7:0] resp_out;
  logic [3:0] resp_flags;
  logic [7:0] alu_x, alu_y, alu_out;
  logic [3:0] alu_sel;
  logic       alu_zero, alu_carry, alu_overflow, alu_negative;
  logic       busy;
  logic [11:0] alu_res;
`ifdef ALU_SCHED_PERF_EN
  logic [15:0] perf_cnt0, perf_cnt1;
  logic [7:0]  perf_err_cnt;
`endif

  always #5 clk = ~clk;

  alu_req_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x),
    .req0_y(req0_y), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x),
    .req1_y(req1_y), .req1_sel(req1_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_out(resp_out), .resp_flags(resp_flags), .resp_err(resp_err),
    .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_negative(alu_negative), .busy(busy)
`ifdef ALU_SCHED_PERF_EN
    , .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1), .perf_err_cnt(perf_err_cnt)
`endif
  );

  // Returns {negative, overflow, carry, zero, result}; opcode 15 yields 0.
  function automatic logic [11:0] alu_ref(input logic [7:0] x, input logic [7:0] y,
                                          input logic [3:0] s);
    logic [8:0] t;
    logic [7:0] r;
    logic       c, v;
    t = '0; c = 1'b0; v = 1'b0;
    case (s)
      4'd0: begin t = {1'b0, x} + {1'b0, y}; r = t[7:0]; c = t[8];
                  v = (x[7] == y[7]) && (r[7] != x[7]); end
      4'd1: begin t = {1'b0, x} - {1'b0, y}; r = t[7:0]; c = t[8];
                  v = (x[7] != y[7]) && (r[7] != x[7]); end
      4'd2:  r = x | y;
      4'd3:  r = x & y;
      4'd4:  r = x ^ y;
      4'd5:  r = ~x;
      4'd6:  begin r = {x[6:0], 1'b0}; c = x[7]; end
      4'd7:  begin r = {1'b0, x[7:1]}; c = x[0]; end
      4'd8:  r = x + 8'd1;
      4'd9:  r = x - 8'd1;
      4'd10: r = x;
      4'd11: r = y;
      4'd12: r = ~(x & y);
      4'd13: r = ~(x | y);
      4'd14: r = (x > y) ? x : y;
      default: r = 8'h00;
    endcase
    return {r[7], v, c, (r == 8'h00), r};
  endfunction

  assign alu_res      = alu_ref(alu_x, alu_y, alu_sel);
  assign alu_out      = alu_res[7:0];
  assign alu_zero     = alu_res[8];
  assign alu_carry    = alu_res[9];
  assign alu_overflow = alu_res[10];
  assign alu_negative = alu_res[11];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Requester-side pending ops and the scheduler reference model
  bit         p_v[2];
  logic [7:0] p_x[2], p_y[2];
  logic [3:0] p_sel[2];
  bit         rnd = 1'b0;
  bit         m_free = 1'b1, m_fav = 1'b0, m_id = 1'b0;
  int         m_age = 0;
  logic [7:0] m_x, m_y;
  logic [3:0] m_sel;
  int         m_pc0 = 0, m_pc1 = 0, m_pe = 0;
  int         id_q[$];
  logic [7:0] out_q[$];
  logic [3:0] flg_q[$];
  bit         err_q[$];

  task automatic drive();
    req0_valid = p_v[0]; req0_x = p_x[0]; req0_y = p_y[0]; req0_sel = p_sel[0];
    req1_valid = p_v[1]; req1_x = p_x[1]; req1_y = p_y[1]; req1_sel = p_sel[1];
  endtask

  task automatic set_op(input int i, input logic [3:0] s, input logic [7:0] x,
                        input logic [7:0] y);
    p_v[i] = 1'b1; p_sel[i] = s; p_x[i] = x; p_y[i] = y;
  endtask

  task automatic clear_log();
    id_q.delete(); out_q.delete(); flg_q.delete(); err_q.delete();
  endtask

  task automatic step();
    bit e_acc, e_gid, e_rv, hs, r_edge;
    logic [11:0] e;
    logic [7:0] o_out;
    logic [3:0] o_flg;
    bit o_id, o_err;
    @(negedge clk);
    e_acc = m_free && (p_v[0] || p_v[1]);
    e_gid = (p_v[0] && p_v[1]) ? m_fav : p_v[1];
    e_rv  = !m_free && (m_age >= 1);
    check("req0_ready", 32'(req0_ready), 32'(e_acc && !e_gid));
    check("req1_ready", 32'(req1_ready), 32'(e_acc && e_gid));
    check("busy", 32'(busy), 32'(!m_free));
    check("resp_valid", 32'(resp_valid), 32'(e_rv));
    if (!m_free) begin
      check("alu_x", 32'(alu_x), 32'(m_x));
      check("alu_y", 32'(alu_y), 32'(m_y));
      check("alu_sel", 32'(alu_sel), 32'(m_sel));
    end
    if (e_rv) begin
      e = alu_ref(m_x, m_y, m_sel);
      check("resp_id", 32'(resp_id), 32'(m_id));
      check("resp_out", 32'(resp_out), 32'(e[7:0]));
      check("resp_flags", 32'(resp_flags), 32'(e[11:8]));
      check("resp_err", 32'(resp_err), 32'(m_sel == 4'd15));
    end
    hs = e_rv && resp_ready;
    o_out = resp_out; o_flg = resp_flags; o_id = resp_id; o_err = resp_err;
    r_edge = rst;
    @(posedge clk);
    #1;
    if (r_edge) begin
      m_free = 1'b1; m_fav = 1'b0; m_age = 0;
      m_pc0 = 0; m_pc1 = 0; m_pe = 0;
    end else if (hs) begin
      m_free = 1'b1;
      id_q.push_back(int'(o_id)); out_q.push_back(o_out);
      flg_q.push_back(o_flg); err_q.push_back(o_err);
      if (m_id) m_pc1 = (m_pc1 < 65535) ? m_pc1 + 1 : m_pc1;
      else      m_pc0 = (m_pc0 < 65535) ? m_pc0 + 1 : m_pc0;
      if (m_sel == 4'd15) m_pe = (m_pe < 255) ? m_pe + 1 : m_pe;
    end else if (e_acc) begin
      m_free = 1'b0; m_age = 0; m_id = e_gid;
      m_x = p_x[e_gid]; m_y = p_y[e_gid]; m_sel = p_sel[e_gid];
      m_fav = !e_gid;
      p_v[e_gid] = 1'b0;
    end else if (!m_free) begin
      m_age++;
    end
    if (rnd) begin
      for (int i = 0; i < 2; i++)
        if (!p_v[i] && $urandom_range(0, 1) == 1)
          set_op(i, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    drive();
  endtask

  task automatic run_until_done(input int bound);
    int n = 0;
    while (!(m_free && !p_v[0] && !p_v[1]) && n < bound) begin
      step();
      n++;
    end
    check("drain_done", 32'(m_free && !p_v[0] && !p_v[1]), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    check({tag, "_resp_out"}, 32'(resp_out), 32'd0);
    check({tag, "_resp_flags"}, 32'(resp_flags), 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check({tag, "_alu_x"}, 32'(alu_x), 32'd0);
    check({tag, "_alu_y"}, 32'(alu_y), 32'd0);
    check({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready0"}, 32'(req0_ready), 32'd0);
    check({tag, "_ready1"}, 32'(req1_ready), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    drive();
    step();
    step();
    check_zero("reset");
    rst = 1'b0;
  endtask

  int n_before;

  initial begin
    for (int i = 0; i < 2; i++) begin p_v[i] = 1'b0; p_x[i] = '0; p_y[i] = '0; p_sel[i] = '0; end
    resp_ready = 1'b0;
    drive();
    @(posedge clk);
    #1;
    do_reset();

    // Add with signed overflow
    clear_log();
    resp_ready = 1'b1;
    set_op(0, 4'd0, 8'h7F, 8'h01); drive();
    run_until_done(20);
    check("add_out", 32'(out_q[0]), 32'h80);
    check("add_flags", 32'(flg_q[0]), 32'b1100);
    check("add_id", 32'(id_q[0]), 32'd0);
    check("add_err", 32'(err_q[0]), 32'd0);

    // Contention straight out of reset, then again with req0 favoured
    do_reset();
    clear_log();
    resp_ready = 1'b1;
    set_op(0, 4'd1, 8'h05, 8'h07);
    set_op(1, 4'd3, 8'hF0, 8'h3C); drive();
    run_until_done(20);
    set_op(0, 4'd4, 8'h12, 8'h34);
    set_op(1, 4'd2, 8'h01, 8'h02); drive();
    run_until_done(20);
    check("cont_n", 32'(id_q.size()), 32'd4);
    check("cont_id0", 32'(id_q[0]), 32'd0);
    check("cont_out0", 32'(out_q[0]), 32'hFE);
    check("cont_flags0", 32'(flg_q[0]), 32'b1010);
    check("cont_id1", 32'(id_q[1]), 32'd1);
    check("cont_out1", 32'(out_q[1]), 32'h30);
    check("cont_id2", 32'(id_q[2]), 32'd0);
    check("cont_id3", 32'(id_q[3]), 32'd1);

    // Backpressure with another request waiting
    clear_log();
    resp_ready = 1'b0;
    set_op(0, 4'd4, 8'h3C, 8'h0F);
    set_op(1, 4'd0, 8'h10, 8'h20); drive();
    for (int i = 0; i < 10 && !(!m_free && m_age >= 1); i++) step();
    for (int i = 0; i < 5; i++) step();
    check("bp_no_resp", 32'(id_q.size()), 32'd0);
    resp_ready = 1'b1;
    run_until_done(20);
    check("bp_n", 32'(id_q.size()), 32'd2);
    check("bp_out0", 32'(out_q[0]), 32'h33);

    // Illegal opcode from requester 1
    clear_log();
    set_op(1, 4'd15, 8'hAA, 8'h55); drive();
    run_until_done(20);
    check("ill_out", 32'(out_q[0]), 32'h00);
    check("ill_flags", 32'(flg_q[0]), 32'b0001);
    check("ill_err", 32'(err_q[0]), 32'd1);
    check("ill_id", 32'(id_q[0]), 32'd1);

    // Reset while the op is in EXEC
    do_reset();
    clear_log();
    resp_ready = 1'b1;
    set_op(0, 4'd0, 8'h11, 8'h22); drive();
    step();
    check("exec_busy", 32'(busy), 32'd1);
    n_before = id_q.size();
    rst = 1'b1;
    step();
    check_zero("rst_exec");
    rst = 1'b0;
    check("rst_exec_dropped", 32'(id_q.size()), 32'(n_before));
    set_op(1, 4'd2, 8'h0F, 8'hF0); drive();
    run_until_done(20);
    check("after_rst_n", 32'(id_q.size()), 32'd1);
    check("after_rst_id", 32'(id_q[0]), 32'd1);
    check("after_rst_out", 32'(out_q[0]), 32'hFF);

    // Random traffic scored against the model
    rnd = 1'b1;
    for (int c = 0; c < 400; c++) step();
    rnd = 1'b0;
    resp_ready = 1'b1;
    run_until_done(40);

`ifdef ALU_SCHED_PERF_EN
    check("perf_rand0", 32'(perf_cnt0), 32'(m_pc0));
    check("perf_rand1", 32'(perf_cnt1), 32'(m_pc1));
    check("perf_rand_err", 32'(perf_err_cnt), 32'(m_pe));
    do_reset();
    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_op((k < 3) ? 0 : 1, (k == 4) ? 4'd15 : 4'd0, 8'(k), 8'h01);
      drive();
      run_until_done(20);
    end
    check("perf_cnt0", 32'(perf_cnt0), 32'd3);
    check("perf_cnt1", 32'(perf_cnt1), 32'd2);
    check("perf_err_cnt", 32'(perf_err_cnt), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_req_sched.md
Name: alu_req_sched

Overview:
- Two-requester round-robin scheduler that shares one combinational 8-bit ALU.
- Accepts operation requests (x, y, sel) over valid/ready handshakes and grants one request at a time.
- Drives the ALU from registered operands, captures the result and flags, and returns them on a single response channel tagged with the requester ID.
- Sits between the two issuing units and the ALU instance.

Parameters:
- DATA_W, 8, operand/result width; must equal the ALU width.
- SEL_W, 4, opcode width.
- MAX_SEL, 14, highest legal opcode; opcodes above it are flagged as errors.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has an op pending.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_x, req0_y  in  DATA_W  requester 0 operands.
- req0_sel  in  SEL_W  requester 0 opcode.
- req1_valid, req1_ready, req1_x, req1_y, req1_sel  same as requester 0, for requester 1.
- resp_valid  out  1  response held valid.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  1  requester that issued the op.
- resp_out  out  DATA_W  captured ALU result.
- resp_flags  out  4  {negative, overflow, carry, zero}.
- resp_err  out  1  opcode exceeded MAX_SEL.
- alu_x, alu_y  out  DATA_W  registered operands to the ALU.
- alu_sel  out  SEL_W  registered opcode to the ALU.
- alu_out  in  DATA_W  ALU result.
- alu_zero, alu_carry, alu_overflow, alu_negative  in  1  ALU flags.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - State goes to IDLE.
  - resp_valid, resp_id, resp_out, resp_flags, resp_err, alu_x, alu_y, alu_sel all 0.
  - RR pointer favours requester 0.
  - busy 0; both ready outputs 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready = (state==IDLE) & grant==N; combinational, one-hot or zero.
  - Grant: if only one valid, grant it; if both valid, grant the requester the pointer favours.
  - On grant, latch x, y, sel into alu_x/alu_y/alu_sel, latch id, and set resp_err = (sel > MAX_SEL).
  - Then toggle the pointer so the other requester is favoured, and go to EXEC.
  - No valid: stay in IDLE; the pointer does not change.
- EXEC (exactly one cycle):
  - ALU inputs are stable from the registers.
  - On the clock edge, capture alu_out into resp_out and the flags into resp_flags.
  - Set resp_valid = 1 and go to RESP.
- RESP:
  - Hold all resp_* stable while resp_valid=1 and resp_ready=0.
  - On resp_valid & resp_ready: clear resp_valid next cycle and go to IDLE.
  - No request is accepted in EXEC or RESP.
- Latency and throughput:
  - Accept at edge N; resp_valid first visible after edge N+1.
  - Minimum issue interval is 3 cycles (accept, exec, resp handshake with resp_ready=1).
- Illegal opcode: it is still sent to the ALU, the ALU's result and flags are passed through, and resp_err is set.
- alu_* keep their last values after completion; there is no requirement to zero them.
- Requester inputs must stay stable while valid=1 and ready=0. The block only samples them on the accept cycle.
- Reset mid-operation (EXEC or RESP):
  - The in-flight op is dropped; no response is produced.
  - All outputs return to their reset values on the next edge.
- Simultaneous valids on the first cycle after reset: requester 0 wins.

Optional Feature:
- Macro: ALU_SCHED_PERF_EN.
- When defined, adds outputs perf_cnt0 and perf_cnt1 (16 bits each).
  - Each counts completed responses (resp_valid & resp_ready) for its resp_id.
  - Counters saturate at 16'hFFFF and clear on rst.
  - Also adds perf_err_cnt (8 bits, saturating), which counts completed responses with resp_err=1.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Add overflow: req0 x=8'h7F, y=8'h01, sel=0, resp_ready=1 -> resp_valid two edges after accept, resp_out=8'h80, flags {1,1,0,0}, resp_id=0, resp_err=0.
- Contention right after reset: both valid, req0 sel=1 x=5 y=7, req1 sel=3 x=F0 y=3C -> req0 served first (out=FE, carry=1, negative=1), then req1 (out=30). With both still valid, req0 is served next.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_* stable, both ready=0, busy=1; after resp_ready=1 for one cycle, back to IDLE.
- Illegal opcode: req1 sel=15 x=AA y=55 -> resp_out=0, zero=1, resp_err=1, resp_id=1.
- Reset in EXEC: assert rst during the EXEC cycle -> no response, all outputs 0 next cycle. A following req1-only op is accepted normally.
- With ALU_SCHED_PERF_EN: 3 req0 ops and 2 req1 ops, one of them with sel=15 -> perf_cnt0=3, perf_cnt1=2, perf_err_cnt=1.
